jtag_tap_param: RTL and testbench

Parametrised second-generation JTAG TAP controller. It uses a binary-encoded IEEE 1149.1 16-state FSM, a configurable IR length and IDCODE, a capture value for IR status bits, and NUM_CH user data-register channels. Each channel is selected by its own opcode. It sits between the JTAG pads and the sub-module scan chains (boundary scan, mbist, debug), which attach as generic channels.

---
 rtl/jtag_pkg.sv | 52 +++++
 rtl/jtag_tap_param_if.sv | 23 ++
 rtl/jtag_tap_fsm.sv | 51 +++++
 rtl/jtag_tap_param.sv | 179 +++++++++++++++++
 tb/tb_jtag_tap_param.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types: IEEE 1149.1 state encoding, default opcodes and the
// next-state function used by the FSM and by the instruction-register logic.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_IDLE         = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam int unsigned IDCODE_OP_DEF = 32'd2;
    localparam int unsigned USER_BASE_DEF = 32'd8;
    localparam logic [1:0]  IR_CAPTURE    = 2'b01;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_IDLE;
            RUN_IDLE:         nxt = tms ? SELECT_DR        : RUN_IDLE;
            SELECT_DR:        nxt = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR        : RUN_IDLE;
            SELECT_IR:        nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR        : RUN_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_param_if.sv
// Channel-side bundle between the TAP and the attached user scan chains:
// DR strobes, one-hot channel select, forwarded TDI and per-channel returns.
interface jtag_tap_param_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              capture_dr_o;
    logic              shift_dr_o;
    logic              pause_dr_o;
    logic              update_dr_o;
    logic              tdo_o;
    logic [NUM_CH-1:0] ch_select_o;
    logic [NUM_CH-1:0] ch_tdi_i;

    modport master (
        output capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, tdo_o, ch_select_o,
        input  ch_tdi_i
    );

    modport slave (
        input  capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, tdo_o, ch_select_o,
        output ch_tdi_i
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller. DR strobes are registered from the next state so
// they line up with the state register without any decode delay.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_pad_i,
    input  logic       trst_n_pad_i,
    input  logic       tms_pad_i,
    output tap_state_e state_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o
);

    tap_state_e state_r;
    tap_state_e next_s;
    logic       capture_dr_r;
    logic       shift_dr_r;
    logic       pause_dr_r;
    logic       update_dr_r;

    // next-state lookup from current state and TMS
    always_comb begin
        next_s = tap_next(state_r, tms_pad_i);
    end

    // state register and strobes; trst overrides TMS
    always_ff @(posedge tck_pad_i) begin
        if (!trst_n_pad_i) begin
            state_r      <= TEST_LOGIC_RESET;
            capture_dr_r <= 1'b0;
            shift_dr_r   <= 1'b0;
            pause_dr_r   <= 1'b0;
            update_dr_r  <= 1'b0;
        end else begin
            state_r      <= next_s;
            capture_dr_r <= (next_s == CAPTURE_DR);
            shift_dr_r   <= (next_s == SHIFT_DR);
            pause_dr_r   <= (next_s == PAUSE_DR);
            update_dr_r  <= (next_s == UPDATE_DR);
        end
    end

    assign state_o      = state_r;
    assign capture_dr_o = capture_dr_r;
    assign shift_dr_o   = shift_dr_r;
    assign pause_dr_o   = pause_dr_r;
    assign update_dr_o  = update_dr_r;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: instruction register, IDCODE and BYPASS data registers,
// opcode decode to NUM_CH external user channels, and the negedge TDO mux.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int unsigned IR_LENGTH    = 4,
    parameter int unsigned NUM_CH       = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
    parameter int unsigned IDCODE_OP    = IDCODE_OP_DEF,
    parameter int unsigned USER_BASE    = USER_BASE_DEF,
    parameter int unsigned BYPASS_OP    = (32'd1 << IR_LENGTH) - 32'd1
) (
    input  logic                 tck_pad_i,
    input  logic                 trst_n_pad_i,
    input  logic                 tms_pad_i,
    input  logic                 tdi_pad_i,
    output logic                 tdo_pad_o,
    output logic                 tdo_padoe_o,
    output logic [3:0]           tap_state_o,
    input  logic [IR_LENGTH-3:0] ir_status_i,
    jtag_tap_param_if.master     ch_bus
);

    localparam logic [IR_LENGTH-1:0] IDCODE_IR = IR_LENGTH'(IDCODE_OP);

    if (IR_LENGTH < 32'd3) begin : g_chk_ir_length
        $fatal(1, "jtag_tap_param: IR_LENGTH must be at least 3");
    end
    if ((NUM_CH < 32'd1) || (NUM_CH > 32'd8)) begin : g_chk_num_ch
        $fatal(1, "jtag_tap_param: NUM_CH must be in 1..8");
    end
    if ((USER_BASE + NUM_CH - 32'd1) >= BYPASS_OP) begin : g_chk_user_range
        $fatal(1, "jtag_tap_param: user opcodes overlap BYPASS_OP");
    end
    if ((IDCODE_OP >= USER_BASE) && (IDCODE_OP < (USER_BASE + NUM_CH))) begin : g_chk_idcode_op
        $fatal(1, "jtag_tap_param: IDCODE_OP inside user opcode range");
    end
    if (IDCODE_VALUE[0] != 1'b1) begin : g_chk_idcode_lsb
        $fatal(1, "jtag_tap_param: IDCODE_VALUE bit 0 must be 1");
    end

    function automatic logic [NUM_CH-1:0] ch_decode(input logic [IR_LENGTH-1:0] ir);
        logic [NUM_CH-1:0] sel;
        sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ir == IR_LENGTH'(USER_BASE + k)) begin
                sel[k] = 1'b1;
            end else begin
                sel[k] = 1'b0;
            end
        end
        return sel;
    endfunction

    tap_state_e           state_s;
    logic                 capture_dr_s;
    logic                 shift_dr_s;
    logic                 pause_dr_s;
    logic                 update_dr_s;
    logic [IR_LENGTH-1:0] ir_shift_r;
    logic [IR_LENGTH-1:0] latched_ir_r;
    logic [IR_LENGTH-1:0] latched_ir_next_s;
    logic [NUM_CH-1:0]    ch_select_r;
    logic                 sel_idcode_r;
    logic [31:0]          idcode_r;
    logic                 bypass_r;
    logic                 tdo_r;
    logic                 tdo_oe_r;

    jtag_tap_fsm u_fsm (
        .tck_pad_i    (tck_pad_i),
        .trst_n_pad_i (trst_n_pad_i),
        .tms_pad_i    (tms_pad_i),
        .state_o      (state_s),
        .capture_dr_o (capture_dr_s),
        .shift_dr_o   (shift_dr_s),
        .pause_dr_o   (pause_dr_s),
        .update_dr_o  (update_dr_s)
    );

    // latched IR follows UpdIR, and snaps to IDCODE on entering or sitting in TLR
    always_comb begin
        latched_ir_next_s = latched_ir_r;
        if ((state_s == TEST_LOGIC_RESET) || (tap_next(state_s, tms_pad_i) == TEST_LOGIC_RESET)) begin
            latched_ir_next_s = IDCODE_IR;
        end else if (state_s == UPDATE_IR) begin
            latched_ir_next_s = ir_shift_r;
        end else begin
            latched_ir_next_s = latched_ir_r;
        end
    end

    // instruction shift/latch registers and registered opcode decode
    always_ff @(posedge tck_pad_i) begin
        if (!trst_n_pad_i) begin
            ir_shift_r   <= '0;
            latched_ir_r <= IDCODE_IR;
            ch_select_r  <= '0;
            sel_idcode_r <= 1'b1;
        end else begin
            latched_ir_r <= latched_ir_next_s;
            ch_select_r  <= ch_decode(latched_ir_next_s);
            sel_idcode_r <= (latched_ir_next_s == IDCODE_IR);
            case (state_s)
                CAPTURE_IR: ir_shift_r <= {ir_status_i, IR_CAPTURE};
                SHIFT_IR:   ir_shift_r <= {tdi_pad_i, ir_shift_r[IR_LENGTH-1:1]};
                default:    ir_shift_r <= ir_shift_r;
            endcase
        end
    end

    // internal data registers; user channels hold their own chains
    always_ff @(posedge tck_pad_i) begin
        if (!trst_n_pad_i) begin
            idcode_r <= IDCODE_VALUE;
            bypass_r <= 1'b0;
        end else begin
            case (state_s)
                CAPTURE_DR: begin
                    idcode_r <= IDCODE_VALUE;
                    bypass_r <= 1'b0;
                end
                SHIFT_DR: begin
                    if (sel_idcode_r) begin
                        idcode_r <= {tdi_pad_i, idcode_r[31:1]};
                    end else if (ch_select_r == '0) begin
                        bypass_r <= tdi_pad_i;
                    end else begin
                        bypass_r <= bypass_r;
                    end
                end
                default: begin
                    idcode_r <= idcode_r;
                    bypass_r <= bypass_r;
                end
            endcase
        end
    end

    // TDO launched on the falling edge so it is stable for the next rising edge
    always_ff @(negedge tck_pad_i) begin
        if (!trst_n_pad_i) begin
            tdo_r    <= 1'b0;
            tdo_oe_r <= 1'b0;
        end else begin
            case (state_s)
                SHIFT_IR: begin
                    tdo_r    <= ir_shift_r[0];
                    tdo_oe_r <= 1'b1;
                end
                SHIFT_DR: begin
                    tdo_oe_r <= 1'b1;
                    if (sel_idcode_r) begin
                        tdo_r <= idcode_r[0];
                    end else if (ch_select_r != '0) begin
                        tdo_r <= |(ch_select_r & ch_bus.ch_tdi_i);
                    end else begin
                        tdo_r <= bypass_r;
                    end
                end
                default: begin
                    tdo_r    <= 1'b0;
                    tdo_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign tdo_pad_o           = tdo_r;
    assign tdo_padoe_o         = tdo_oe_r;
    assign tap_state_o         = state_s;
    assign ch_bus.capture_dr_o = capture_dr_s;
    assign ch_bus.shift_dr_o   = shift_dr_s;
    assign ch_bus.pause_dr_o   = pause_dr_s;
    assign ch_bus.update_dr_o  = update_dr_s;
    assign ch_bus.ch_select_o  = ch_select_r;
    assign ch_bus.tdo_o        = tdi_pad_i;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: a table-driven TAP reference model pushes
// expected per-cycle observations; a monitor pops and compares at each falling edge.
module tb_jtag_tap_param;

    localparam int          L    = 4;
    localparam int          NCH  = 4;
    localparam logic [31:0] IDV  = 32'h149511C3;
    localparam int          IDOP = 2;
    localparam int          UB   = 8;

    logic       tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       oe;
    logic [3:0] st;
    logic [1:0] ir_status = 2'b00;

    jtag_tap_param_if #(.NUM_CH(NCH)) ch_bus ();

    jtag_tap_param #(
        .IR_LENGTH(L), .NUM_CH(NCH), .IDCODE_VALUE(IDV),
        .IDCODE_OP(IDOP), .USER_BASE(UB), .BYPASS_OP(15)
    ) dut (
        .tck_pad_i    (tck),
        .trst_n_pad_i (trst_n),
        .tms_pad_i    (tms),
        .tdi_pad_i    (tdi),
        .tdo_pad_o    (tdo),
        .tdo_padoe_o  (oe),
        .tap_state_o  (st),
        .ir_status_i  (ir_status),
        .ch_bus       (ch_bus)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic [3:0] st;
        logic       oe, tdo, cap, sh, pau, upd, fwd;
        logic [3:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   tdo_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pause_seen = 0;

    // TAP transition tables indexed by the IEEE state code
    int nx0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nx1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int          m_st = 15;
    logic [3:0]  m_irsh = 4'h0;
    logic [3:0]  m_ir = 4'(IDOP);
    logic [31:0] m_idc = IDV;
    logic        m_byp = 1'b0;

    function automatic bit is_user(input logic [3:0] ir);
        return (int'(ir) >= UB) && (int'(ir) < UB + NCH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_word(input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < n && i < tdo_log.size(); i++) w[i] = (tdo_log[i] != 0);
        return w;
    endfunction

    task automatic step(input logic t_ms, input logic t_di, input logic t_rst_n = 1'b1);
        exp_t       e;
        logic [3:0] chv;
        chv = 4'($urandom);
        tms = t_ms;
        tdi = t_di;
        trst_n = t_rst_n;
        ch_bus.ch_tdi_i = chv;
        if (!t_rst_n) begin
            m_st = 15; m_irsh = 4'h0; m_ir = 4'(IDOP); m_byp = 1'b0;
        end else begin
            case (m_st)
                14: m_irsh = {ir_status, 2'b01};
                10: m_irsh = {t_di, m_irsh[3:1]};
                13: m_ir = m_irsh;
                6:  begin m_idc = IDV; m_byp = 1'b0; end
                2:  begin
                    if (int'(m_ir) == IDOP) m_idc = {t_di, m_idc[31:1]};
                    else if (!is_user(m_ir)) m_byp = t_di;
                end
                default: ;
            endcase
            m_st = t_ms ? nx1[m_st] : nx0[m_st];
            if (m_st == 15) m_ir = 4'(IDOP);
        end
        e.st  = 4'(m_st);
        e.oe  = (m_st == 10) || (m_st == 2);
        e.cap = (m_st == 6);
        e.sh  = (m_st == 2);
        e.pau = (m_st == 3);
        e.upd = (m_st == 5);
        e.fwd = t_di;
        e.sel = is_user(m_ir) ? 4'(1 << (int'(m_ir) - UB)) : 4'h0;
        if (m_st == 10)     e.tdo = m_irsh[0];
        else if (m_st == 2) e.tdo = (int'(m_ir) == IDOP) ? m_idc[0] :
                                    is_user(m_ir) ? chv[int'(m_ir) - UB] : m_byp;
        else                e.tdo = 1'b0;
        exp_q.push_back(e);
        @(posedge tck);
        @(negedge tck);
        #2;
    endtask

    // monitor: compare every observable once per cycle, away from both edges
    initial begin
        exp_t e;
        forever begin
            @(negedge tck);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",     32'(st), 32'(e.st));
                chk("tdo_oe",    32'(oe), 32'(e.oe));
                chk("tdo",       32'(tdo), 32'(e.tdo));
                chk("capture",   32'(ch_bus.capture_dr_o), 32'(e.cap));
                chk("shift",     32'(ch_bus.shift_dr_o), 32'(e.sh));
                chk("pause",     32'(ch_bus.pause_dr_o), 32'(e.pau));
                chk("update",    32'(ch_bus.update_dr_o), 32'(e.upd));
                chk("ch_select", 32'(ch_bus.ch_select_o), 32'(e.sel));
                chk("tdo_fwd",   32'(ch_bus.tdo_o), 32'(e.fwd));
                if (oe) tdo_log.push_back(int'(tdo));
                if (ch_bus.pause_dr_o) pause_seen++;
            end
        end
    end

    task automatic shift_ir(input logic [3:0] v);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < L; i++) step(i == L - 1, v[i]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] d);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(i == n - 1, d[i]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    initial begin
        ch_bus.ch_tdi_i = 4'h0;
        @(negedge tck);
        #2;

        // reset, then IDCODE read
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        chk("reset_state", 32'(st), 32'hF);
        chk("reset_oe", 32'(oe), 32'h0);
        step(1'b0, 1'b0);
        tdo_log.delete();
        shift_dr(32, $urandom);
        chk("idcode_read", log_word(32), IDV);
        chk("idcode_oe_cycles", 32'(tdo_log.size()), 32'd32);

        // IR scan with status bits, then channel 2 selected
        ir_status = 2'b10;
        tdo_log.delete();
        shift_ir(4'hA);
        chk("ir_capture_bits", log_word(4), 32'h9);
        chk("sel_after_update", 32'(ch_bus.ch_select_o), 32'h4);
        shift_dr(8, $urandom);

        // five TMS=1 from Shift-DR return to TLR and IDCODE
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tms5_state", 32'(st), 32'hF);
        chk("tms5_select", 32'(ch_bus.ch_select_o), 32'h0);
        step(1'b0, 1'b0);
        tdo_log.delete();
        shift_dr(32, 32'h0);
        chk("idcode_after_tms5", log_word(32), IDV);

        // BYPASS and an unused opcode both give one cycle of delay
        shift_ir(4'hF);
        tdo_log.delete();
        shift_dr(8, 32'h4D);
        chk("bypass_op_F", log_word(8), 32'h9A);
        shift_ir(4'h5);
        tdo_log.delete();
        shift_dr(8, 32'h4D);
        chk("bypass_op_5", log_word(8), 32'h9A);

        // pause in the middle of an IDCODE read
        shift_ir(4'h2);
        tdo_log.delete();
        pause_seen = 0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'($urandom));
        step(1'b1, 1'($urandom));
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 21; i++) step(1'b0, 1'($urandom));
        step(1'b1, 1'($urandom));
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("pause_idcode", log_word(32), IDV);
        chk("pause_oe_cycles", 32'(tdo_log.size()), 32'd32);
        chk("pause_cycles", 32'(pause_seen), 32'd3);

        // reset in the middle of an IR shift
        shift_ir(4'hA);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("midscan_rst_state", 32'(st), 32'hF);
        chk("midscan_rst_oe", 32'(oe), 32'h0);
        chk("midscan_rst_select", 32'(ch_bus.ch_select_o), 32'h0);
        step(1'b0, 1'b0);
        tdo_log.delete();
        shift_dr(32, 32'h0);
        chk("idcode_after_rst", log_word(32), IDV);

        // random walk against the model
        for (int i = 0; i < 800; i++) begin
            ir_status = 2'($urandom);
            step(($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 63) != 0));
        end
        step(1'b1, 1'b0, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
